// File: rtl/bus_mem_interface_pkg.sv
// -----------------------------------------------------------------------------
// bus_mem_interface_pkg
// Shared definitions for the memory-side bus stage: the bus width, the
// transaction state encoding and a helper that sizes the wait counter.
// -----------------------------------------------------------------------------
package bus_mem_interface_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Wait counter width: enough bits to count up to the limit without wrapping.
  function automatic int wait_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bus_mem_interface_bus_driver.sv
// -----------------------------------------------------------------------------
// bus_driver
// Enable-gated tristate bus source. Every source on the shared bus goes
// through one of these, so only the enabled source drives the bus.
//   en   : drive d onto bus when 1
//   d    : value to drive
//   bus  : tristate output, all Z when en=0
// -----------------------------------------------------------------------------
module bus_driver #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] d,
  output tri   [W-1:0] bus
);

  assign bus = en ? d : {W{1'bz}};

endmodule

// File: rtl/bus_mem_interface.sv
// -----------------------------------------------------------------------------
// bus_mem_interface
// Memory-side bus stage. Captures an address (MAR) and write data (MDR) from
// the shared bus, runs one read or write handshake at a time with external
// RAM under a bounded wait, and drives MDR back onto the bus on request.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   BUS_IN / BUS_OUT    : shared bus in; MDR out (Z unless mdr_enable)
//   load_mar, load_mdr  : capture BUS_IN into MAR / MDR (IDLE only)
//   mdr_enable          : drive MDR onto BUS_OUT (any state)
//   start_read/_write   : request a transaction (IDLE only; both = error)
//   busy, done, err     : in-progress flag; one-cycle completion/error pulses
//   mem_addr, mem_wdata : always MAR / MDR
//   mem_re, mem_we      : strobes held until mem_ready or timeout
//   mem_rdata, mem_ready: RAM read data and completion
// -----------------------------------------------------------------------------
module bus_mem_interface
  import bus_mem_interface_pkg::*;
#(
  parameter int DATA_W     = BUS_W,
  parameter int ADDR_W     = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] BUS_IN,
  output tri   [DATA_W-1:0] BUS_OUT,
  input  logic              load_mar,
  input  logic              load_mdr,
  input  logic              mdr_enable,
  input  logic              start_read,
  input  logic              start_write,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int                CNT_W    = wait_cnt_w(WAIT_LIMIT);
  // The counter holds the number of ready-low cycles already seen, so the
  // final allowed cycle is the one where it reads WAIT_LIMIT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [ADDR_W-1:0]  mar;
  logic [DATA_W-1:0]  mdr;
  logic               done_nx, err_nx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mar   <= '0;
      mdr   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
      err   <= err_nx;
      // Loads only in IDLE keep MAR/MDR stable for the whole transaction;
      // a load coinciding with a start lands before the first strobe cycle.
      if (state == ST_IDLE) begin
        if (load_mar) mar <= BUS_IN[ADDR_W-1:0];
        if (load_mdr) mdr <= BUS_IN;
      end else if (state == ST_READ && mem_ready) begin
        mdr <= mem_rdata;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (start_read && start_write) err_nx   = 1'b1;
        else if (start_read)           state_nx = ST_READ;
        else if (start_write)          state_nx = ST_WRITE;
      end
      ST_READ, ST_WRITE: begin
        if (mem_ready) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so an async reset
  // drops them immediately.
  assign busy      = (state != ST_IDLE);
  assign mem_re    = (state == ST_READ);
  assign mem_we    = (state == ST_WRITE);
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

  bus_driver #(.W(DATA_W)) u_mdr_drv (
    .en  (mdr_enable),
    .d   (mdr),
    .bus (BUS_OUT)
  );

endmodule
